cr_lz77_comp_match_seq: RTL and testbench



---
 rtl/cr_lz77_comp_match_seq.sv | 135 +++++++++++++
 tb/tb_cr_lz77_comp_match_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cr_lz77_comp_match_seq.sv
// cr_lz77_comp_match_seq
//
// Sequential best-match reducer for the LZ77 compressor match path.
// It accepts a burst of thermometer-coded match-length candidates, one per
// cycle, over a valid/ready stream. A later candidate replaces the winning
// index only when it sets a bit, inside the unmasked low field, that the
// running best lacks. When the burst ends, the block presents the merged
// thermometer, the winner index, the candidate count and an overflow flag.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cand_valid/cand_ready candidate stream handshake
//   cand_therm            candidate thermometer (T_WIDTH bits)
//   cand_last             marks the final candidate of a burst
//   res_valid/res_ready   result stream handshake
//   res_therm             OR of all in-range candidates
//   res_idx               index of the winning candidate (0 = first)
//   res_count             candidates counted, saturating at 2^IDX_W
//   res_ovfl              burst held more than 2^IDX_W candidates

module cr_lz77_comp_match_seq #(
   parameter int T_WIDTH = 4,
   parameter int T_MASK  = 0,
   parameter int IDX_W   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cand_valid,
   output logic               cand_ready,
   input  logic [T_WIDTH-1:0] cand_therm,
   input  logic               cand_last,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [T_WIDTH-1:0] res_therm,
   output logic [IDX_W-1:0]   res_idx,
   output logic [IDX_W:0]     res_count,
   output logic               res_ovfl
);

   // Top bit of the field that takes part in the select comparison.
   localparam int T_MSB = T_WIDTH - T_MASK - 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [IDX_W:0] CNT_ONE = {{IDX_W{1'b0}}, 1'b1};

   logic [1:0]         state_q, state_d;
   logic [T_WIDTH-1:0] best_q,  best_d;
   logic [IDX_W-1:0]   idx_q,   idx_d;
   logic [IDX_W:0]     cnt_q,   cnt_d;
   logic               ovfl_q,  ovfl_d;

   logic cand_acc;
   logic sel;
   logic cnt_full;

   assign cand_ready = (state_q != ST_DONE);
   assign res_valid  = (state_q == ST_DONE);
   assign cand_acc   = cand_valid & cand_ready;

   // Candidate brings a new length bit within the compared field.
   assign sel = |(~best_q[T_MSB:0] & cand_therm[T_MSB:0]);

   // The MSB of the counter alone marks saturation at 2^IDX_W.
   assign cnt_full = cnt_q[IDX_W];

   always_comb begin
      state_d = state_q;
      best_d  = best_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      ovfl_d  = ovfl_q;

      case (state_q)
         ST_IDLE: begin
            if (cand_acc) begin
               best_d  = cand_therm;
               idx_d   = '0;
               cnt_d   = CNT_ONE;
               ovfl_d  = 1'b0;
               state_d = cand_last ? ST_DONE : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (cand_acc) begin
               if (!cnt_full) begin
                  best_d = best_q | cand_therm;
                  // Ties keep the earlier index: only a new bit moves it.
                  if (sel) begin
                     idx_d = cnt_q[IDX_W-1:0];
                  end
                  cnt_d = cnt_q + CNT_ONE;
               end else begin
                  ovfl_d = 1'b1;
               end
               if (cand_last) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         best_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         ovfl_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         best_q  <= best_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         ovfl_q  <= ovfl_d;
      end
   end

   assign res_therm = best_q;
   assign res_idx   = idx_q;
   assign res_count = cnt_q;
   assign res_ovfl  = ovfl_q;

endmodule

// File: tb/tb_cr_lz77_comp_match_seq.sv
// Testbench for cr_lz77_comp_match_seq.
// Two instances share one stimulus stream: a default one (T_MASK=0, IDX_W=4)
// and a narrow one (T_MASK=1, IDX_W=2). Handshake timing is parameter
// independent, so both run in lockstep against a burst-level reference model.

module tb_cr_lz77_comp_match_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       cand_valid = 1'b0;
   logic       cand_last  = 1'b0;
   logic [3:0] cand_therm = '0;
   logic       res_ready  = 1'b0;

   logic       cand_ready0, res_valid0, res_ovfl0;
   logic [3:0] res_therm0, res_idx0;
   logic [4:0] res_count0;

   logic       cand_ready1, res_valid1, res_ovfl1;
   logic [3:0] res_therm1;
   logic [1:0] res_idx1;
   logic [2:0] res_count1;

   cr_lz77_comp_match_seq #(.T_WIDTH(4), .T_MASK(0), .IDX_W(4)) dut0 (
      .clk        (clk),
      .rst_n      (rst_n),
      .cand_valid (cand_valid),
      .cand_ready (cand_ready0),
      .cand_therm (cand_therm),
      .cand_last  (cand_last),
      .res_valid  (res_valid0),
      .res_ready  (res_ready),
      .res_therm  (res_therm0),
      .res_idx    (res_idx0),
      .res_count  (res_count0),
      .res_ovfl   (res_ovfl0)
   );

   cr_lz77_comp_match_seq #(.T_WIDTH(4), .T_MASK(1), .IDX_W(2)) dut1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .cand_valid (cand_valid),
      .cand_ready (cand_ready1),
      .cand_therm (cand_therm),
      .cand_last  (cand_last),
      .res_valid  (res_valid1),
      .res_ready  (res_ready),
      .res_therm  (res_therm1),
      .res_idx    (res_idx1),
      .res_count  (res_count1),
      .res_ovfl   (res_ovfl1)
   );

   logic [3:0] burst[$];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   // Burst-level reference: only the first 2^idxw candidates count; an index
   // moves when a candidate adds a bit inside the unmasked field.
   task automatic model(input int mask, input int idxw, output logic [3:0] therm,
                        output int idx, output int cnt, output bit ovfl);
      int cap;
      logic [3:0] field;
      cap   = 1 << idxw;
      field = 4'hF >> mask;
      therm = '0;
      idx   = 0;
      cnt   = 0;
      ovfl  = 1'b0;
      for (int k = 0; k < burst.size(); k++) begin
         if (k >= cap) begin
            ovfl = 1'b1;
         end else begin
            if (k > 0 && ((burst[k] & ~therm & field) != 4'h0)) idx = k;
            therm = therm | burst[k];
            cnt   = k + 1;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cmp_done(input string tag);
      logic [3:0] t0, t1;
      int i0, i1, c0, c1;
      bit o0, o1;
      model(0, 4, t0, i0, c0, o0);
      model(1, 2, t1, i1, c1, o1);
      check({tag, ".valid0"}, res_valid0, 1);
      check({tag, ".valid1"}, res_valid1, 1);
      check({tag, ".cready0"}, cand_ready0, 0);
      check({tag, ".cready1"}, cand_ready1, 0);
      check({tag, ".therm0"}, res_therm0, t0);
      check({tag, ".idx0"}, res_idx0, i0);
      check({tag, ".count0"}, res_count0, c0);
      check({tag, ".ovfl0"}, res_ovfl0, o0);
      check({tag, ".therm1"}, res_therm1, t1);
      check({tag, ".idx1"}, res_idx1, i1);
      check({tag, ".count1"}, res_count1, c1);
      check({tag, ".ovfl1"}, res_ovfl1, o1);
   endtask

   // Called one cycle after the last accept; holds off res_ready for hold cycles.
   task automatic finish_burst(input string tag, input int hold);
      cmp_done(tag);
      for (int h = 0; h < hold; h++) begin
         step();
         cmp_done({tag, ".hold"});
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check({tag, ".post_valid"}, res_valid0, 0);
      check({tag, ".post_cready"}, cand_ready0, 1);
   endtask

   task automatic send_burst(input int gap_pct);
      for (int i = 0; i < burst.size(); i++) begin
         while ($urandom_range(99) < gap_pct) begin
            cand_valid = 1'b0;
            cand_therm = 4'($urandom);
            cand_last  = 1'($urandom);
            step();
         end
         cand_valid = 1'b1;
         cand_therm = burst[i];
         cand_last  = (i == burst.size() - 1);
         check("beat.cready", {cand_ready0, cand_ready1}, 2'b11);
         step();
      end
      cand_valid = 1'b0;
      cand_last  = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".valid"}, {res_valid0, res_valid1}, 0);
      check({tag, ".cready"}, {cand_ready0, cand_ready1}, 2'b11);
      check({tag, ".therm"}, {res_therm0, res_therm1}, 0);
      check({tag, ".idx"}, {res_idx0, res_idx1}, 0);
      check({tag, ".count"}, {res_count0, res_count1}, 0);
      check({tag, ".ovfl"}, {res_ovfl0, res_ovfl1}, 0);
   endtask

   initial begin
      step();
      step();
      check_reset("reset");
      rst_n = 1'b1;
      step();

      burst = '{4'b0011};
      send_burst(0);
      finish_burst("single", 0);

      burst = '{4'b0001, 4'b0111, 4'b0011, 4'b0111};
      send_burst(0);
      finish_burst("tie", 0);

      burst = '{4'b0011, 4'b1011};
      send_burst(0);
      finish_burst("mask", 0);

      burst = '{4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b1111};
      send_burst(0);
      finish_burst("ovfl", 0);

      burst = '{4'b0001};
      send_burst(0);
      finish_burst("ovfl_clear", 0);

      // Backpressure with a pending candidate waiting during DONE.
      burst = '{4'b0111};
      send_burst(0);
      cand_valid = 1'b1;
      cand_therm = 4'b0101;
      cand_last  = 1'b1;
      finish_burst("bp", 3);
      step();
      cand_valid = 1'b0;
      cand_last  = 1'b0;
      burst = '{4'b0101};
      finish_burst("bp_next", 0);

      // Asynchronous reset in the middle of a burst.
      cand_valid = 1'b1;
      cand_last  = 1'b0;
      cand_therm = 4'b0001;
      step();
      cand_therm = 4'b0011;
      step();
      cand_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_reset("midrst");
      #2 rst_n = 1'b1;
      burst = '{4'b0111};
      send_burst(0);
      finish_burst("after_rst", 0);

      for (int b = 0; b < 40; b++) begin
         int len;
         len = $urandom_range(1, 20);
         burst.delete();
         for (int i = 0; i < len; i++) begin
            logic [4:0] ones;
            ones = 5'd1 << $urandom_range(0, 4);
            burst.push_back(4'(ones - 5'd1));
         end
         send_burst(20);
         finish_burst("rand", $urandom_range(0, 2));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
